ahb_arbiter: RTL and testbench

AHB_ARBITER -- requirements
Module: ahb_arbiter

---
 rtl/ahb_arbiter_if.sv | 41 ++++
 rtl/ahb_arbiter.sv | 101 ++++++++++
 tb/tb_ahb_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ahb_arbiter_if.sv
// ahb_arbiter_if
//   Bus-side signal bundle for the two-master AHB arbiter.
//   slave modport  : the arbiter's view (requests and master buses in,
//                    grant, ownership and the muxed bus out).
//   master modport : the surrounding masters/testbench view (mirror image).
//   Packed master buses are {master2, master1}; bit/field 0 is master1.
interface ahb_arbiter_if;
  logic [1:0]  HBUSREQ;
  logic [1:0]  HLOCK;
  logic [3:0]  HTRANS_M;
  logic [63:0] HADDR_M;
  logic [1:0]  HWRITE_M;
  logic [7:0]  HSIZE_M;
  logic [5:0]  HBURST_M;
  logic [63:0] HWDATA_M;
  logic        HREADY;

  logic [1:0]  HGRANT;
  logic        HMASTER;
  logic        HMASTLOCK;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [3:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;

  modport slave (
    input  HBUSREQ, HLOCK, HTRANS_M, HADDR_M, HWRITE_M, HSIZE_M, HBURST_M,
           HWDATA_M, HREADY,
    output HGRANT, HMASTER, HMASTLOCK, HADDR, HTRANS, HWRITE, HSIZE, HBURST,
           HWDATA
  );

  modport master (
    output HBUSREQ, HLOCK, HTRANS_M, HADDR_M, HWRITE_M, HSIZE_M, HBURST_M,
           HWDATA_M, HREADY,
    input  HGRANT, HMASTER, HMASTLOCK, HADDR, HTRANS, HWRITE, HSIZE, HBURST,
           HWDATA
  );
endinterface

// File: rtl/ahb_arbiter.sv
// ahb_arbiter
//   Two-master AHB bus arbiter with address/control and write-data muxes.
//   Ports:
//     HCLK    - clock, all state changes on the rising edge
//     HRESET  - synchronous active-high reset
//     bus     - ahb_arbiter_if.slave: HBUSREQ/HLOCK/master buses/HREADY in,
//               HGRANT/HMASTER/HMASTLOCK (registered) and the muxed
//               HADDR/HTRANS/HWRITE/HSIZE/HBURST/HWDATA (combinational) out.
//   Ownership moves only on HREADY=1 edges, never splits a burst (owner in
//   SEQ/BUSY) and never breaks a lock while the owner still requests.
//   HWDATA follows a data-phase owner that lags HMASTER by one transfer.
module ahb_arbiter #(
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input logic         HCLK,
  input logic         HRESET,
  ahb_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic       DefMaster = DEFAULT_MASTER[0];
  localparam logic [1:0] DefGrant  = DefMaster ? 2'b10 : 2'b01;

  logic       hmaster_q,    hmaster_d;
  logic [1:0] hgrant_q,     hgrant_d;
  logic       hmastlock_q,  hmastlock_d;
  logic       data_owner_q, data_owner_d;

  htrans_e    owner_trans;
  logic       burst_active;
  logic       lock_hold;
  logic       winner;
  logic       next_owner;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    hmaster_d    = hmaster_q;
    hgrant_d     = hgrant_q;
    hmastlock_d  = hmastlock_q;
    data_owner_d = data_owner_q;

    owner_trans  = htrans_e'(hmaster_q ? bus.HTRANS_M[3:2] : bus.HTRANS_M[1:0]);
    burst_active = (owner_trans == HTRANS_SEQ) || (owner_trans == HTRANS_BUSY);
    // A lock bit counts only while the owner is still requesting.
    lock_hold    = bus.HLOCK[hmaster_q] & bus.HBUSREQ[hmaster_q];

    unique case (bus.HBUSREQ)
      2'b11:   winner = ~hmaster_q;   // contention: the non-owner gets its turn
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      default: winner = DefMaster;
    endcase

    next_owner = (burst_active || lock_hold) ? hmaster_q : winner;

    if (bus.HREADY) begin
      hmaster_d    = next_owner;
      hgrant_d     = next_owner ? 2'b10 : 2'b01;
      hmastlock_d  = bus.HLOCK[next_owner] & bus.HBUSREQ[next_owner];
      data_owner_d = hmaster_q;
    end
  end

  always_ff @(posedge HCLK) begin
    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (HRESET) begin
      hmaster_q    <= DefMaster;
      hgrant_q     <= DefGrant;
      hmastlock_q  <= 1'b0;
      data_owner_q <= DefMaster;
    end else begin
      hmaster_q    <= hmaster_d;
      hgrant_q     <= hgrant_d;
      hmastlock_q  <= hmastlock_d;
      data_owner_q <= data_owner_d;
    end
  end

  assign bus.HGRANT    = hgrant_q;
  assign bus.HMASTER   = hmaster_q;
  assign bus.HMASTLOCK = hmastlock_q;

  // Address/control follow the address-phase owner.
  assign bus.HADDR  = hmaster_q ? bus.HADDR_M[63:32] : bus.HADDR_M[31:0];
  assign bus.HTRANS = hmaster_q ? bus.HTRANS_M[3:2]  : bus.HTRANS_M[1:0];
  assign bus.HWRITE = hmaster_q ? bus.HWRITE_M[1]    : bus.HWRITE_M[0];
  assign bus.HSIZE  = hmaster_q ? bus.HSIZE_M[7:4]   : bus.HSIZE_M[3:0];
  assign bus.HBURST = hmaster_q ? bus.HBURST_M[5:3]  : bus.HBURST_M[2:0];

  // Write data belongs to the transfer whose address phase came one earlier.
  assign bus.HWDATA = data_owner_q ? bus.HWDATA_M[63:32] : bus.HWDATA_M[31:0];

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter
//   Directed self-checking bench for ahb_arbiter (DEFAULT_MASTER = 0).
//   Inputs change #1 after a rising edge; outputs are checked there too.
module tb_ahb_arbiter;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [31:0] M1_DATA = 32'h0000_0005;
  localparam logic [31:0] M2_DATA = 32'h0000_5555;
  localparam logic [31:0] M1_ADDR = 32'h1000_0000;
  localparam logic [31:0] M2_ADDR = 32'h2000_0000;

  ahb_arbiter_if bus ();

  ahb_arbiter #(.DEFAULT_MASTER(0)) dut (
    .HCLK   (clk),
    .HRESET (rst),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle; exactly one grant bit must always be high.
  task automatic step();
    @(posedge clk);
    #1;
    check("onehot", 64'($onehot(bus.HGRANT)), 64'd1);
  endtask

  task automatic check_own(input string tag, input logic [1:0] g, input logic m);
    check({tag, ".grant"},   64'(bus.HGRANT),  64'(g));
    check({tag, ".hmaster"}, 64'(bus.HMASTER), 64'(m));
  endtask

  initial begin
    rst          = 1'b1;
    bus.HBUSREQ  = 2'b00;
    bus.HLOCK    = 2'b00;
    bus.HTRANS_M = 4'b0000;
    bus.HADDR_M  = {M2_ADDR, M1_ADDR};
    bus.HWRITE_M = 2'b10;
    bus.HSIZE_M  = {4'h2, 4'h1};
    bus.HBURST_M = {3'h1, 3'h3};
    bus.HWDATA_M = {M2_DATA, M1_DATA};
    bus.HREADY   = 1'b1;

    // Reset, then idle with no requests: default master parked, unlocked.
    step();
    step();
    check_own("reset", 2'b01, 1'b0);
    check("reset.mastlock", 64'(bus.HMASTLOCK), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_own("idle", 2'b01, 1'b0);
      check("idle.mastlock", 64'(bus.HMASTLOCK), 64'd0);
    end

    // Master2 locked request takes the bus and holds it against master1.
    bus.HBUSREQ = 2'b10;
    bus.HLOCK   = 2'b10;
    step();
    check_own("lock.take", 2'b10, 1'b1);
    check("lock.mastlock", 64'(bus.HMASTLOCK), 64'd1);
    bus.HBUSREQ = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      check_own("lock.hold", 2'b10, 1'b1);
    end
    bus.HBUSREQ = 2'b01;
    bus.HLOCK   = 2'b00;
    step();
    check_own("lock.release", 2'b01, 1'b0);
    check("lock.release.mastlock", 64'(bus.HMASTLOCK), 64'd0);

    // Both request single NONSEQ transfers: grant alternates, HWDATA lags.
    // Data owner is master2 (loaded from HMASTER at the previous handover).
    bus.HBUSREQ  = 2'b11;
    bus.HTRANS_M = 4'b1010;
    #1;
    check("mux.haddr1",  64'(bus.HADDR),  64'(M1_ADDR));
    check("mux.htrans1", 64'(bus.HTRANS), 64'd2);
    check("mux.hwrite1", 64'(bus.HWRITE), 64'd0);
    check("mux.hsize1",  64'(bus.HSIZE),  64'd1);
    check("mux.hburst1", 64'(bus.HBURST), 64'd3);
    check("mux.hwdata0", 64'(bus.HWDATA), 64'(M2_DATA));
    step();
    check_own("alt.1", 2'b10, 1'b1);
    check("mux.haddr2",  64'(bus.HADDR),  64'(M2_ADDR));
    check("mux.hwrite2", 64'(bus.HWRITE), 64'd1);
    check("mux.hsize2",  64'(bus.HSIZE),  64'd2);
    check("mux.hburst2", 64'(bus.HBURST), 64'd1);
    check("alt.1.hwdata", 64'(bus.HWDATA), 64'(M1_DATA));
    step();
    check_own("alt.2", 2'b01, 1'b0);
    check("alt.2.hwdata", 64'(bus.HWDATA), 64'(M2_DATA));
    step();
    check_own("alt.3", 2'b10, 1'b1);
    check("alt.3.hwdata", 64'(bus.HWDATA), 64'(M1_DATA));
    step();
    check_own("alt.4", 2'b01, 1'b0);
    check("alt.4.hwdata", 64'(bus.HWDATA), 64'(M2_DATA));

    // Master1 INCR4 burst with one BUSY beat; master2 joins after NONSEQ.
    bus.HBUSREQ  = 2'b01;
    bus.HTRANS_M = 4'b0010;
    step();
    check_own("burst.nonseq", 2'b01, 1'b0);
    bus.HBUSREQ  = 2'b11;
    bus.HTRANS_M = 4'b0011;
    step();
    check_own("burst.seq1", 2'b01, 1'b0);
    bus.HTRANS_M = 4'b0001;
    step();
    check_own("burst.busy", 2'b01, 1'b0);
    bus.HTRANS_M = 4'b0011;
    step();
    check_own("burst.seq2", 2'b01, 1'b0);
    step();
    check_own("burst.seq3", 2'b01, 1'b0);
    bus.HTRANS_M = 4'b0000;
    step();
    check_own("burst.end", 2'b10, 1'b1);

    // Owner drops, other requests, but HREADY low: everything frozen.
    bus.HBUSREQ = 2'b01;
    bus.HREADY  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_own("wait", 2'b10, 1'b1);
      check("wait.hwdata", 64'(bus.HWDATA), 64'(M1_DATA));
    end
    bus.HREADY = 1'b1;
    step();
    check_own("wait.switch", 2'b01, 1'b0);
    check("wait.switch.hwdata", 64'(bus.HWDATA), 64'(M2_DATA));

    // Lock bits without matching requests have no effect.
    bus.HBUSREQ = 2'b00;
    bus.HLOCK   = 2'b10;
    step();
    check_own("lock.noreq", 2'b01, 1'b0);
    check("lock.noreq.mastlock", 64'(bus.HMASTLOCK), 64'd0);
    bus.HBUSREQ = 2'b10;
    bus.HLOCK   = 2'b01;
    step();
    check_own("lock.ownernoreq", 2'b10, 1'b1);
    check("lock.ownernoreq.mastlock", 64'(bus.HMASTLOCK), 64'd0);

    // Reset during a locked master2 burst abandons ownership even with HREADY=0.
    bus.HLOCK = 2'b10;
    step();
    check("rlock.mastlock", 64'(bus.HMASTLOCK), 64'd1);
    bus.HTRANS_M = 4'b1100;
    bus.HREADY   = 1'b0;
    rst          = 1'b1;
    step();
    check_own("rlock.reset", 2'b01, 1'b0);
    check("rlock.reset.mastlock", 64'(bus.HMASTLOCK), 64'd0);
    check("rlock.reset.hwdata", 64'(bus.HWDATA), 64'(M1_DATA));
    rst          = 1'b0;
    bus.HREADY   = 1'b1;
    bus.HBUSREQ  = 2'b00;
    bus.HLOCK    = 2'b00;
    bus.HTRANS_M = 4'b0000;
    step();
    check_own("rlock.after", 2'b01, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
